regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/rv_regfile_pkg.sv | 12 +
 rtl/regfile_clear_seq.sv | 54 +++++
 rtl/regfile_mp.sv | 87 ++++++++
 3 files changed

// File: rtl/rv_regfile_pkg.sv
// rtl/rv_regfile_pkg.sv - shared types and default sizes for the multi-port register file
package rv_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear sequencer: zeroes every register once, then raises ready
module regfile_clear_seq
  import rv_regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          Clk,
  input  logic          Rst,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the sweep from register 0
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one register per cycle; the counter parks at the last index instead of wrapping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_we_o   = 1'b0;
    ready_o    = 1'b0;
    clr_addr_o = cnt_q;
    case (state_q)
      CLEAR: begin
        clr_we_o = 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with x0 hardwired to zero; REGFILE_BYPASS_EN selects write-first reads
module regfile_mp
  import rv_regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  output logic              ready,
  output logic              wr_drop
);

  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] rd_q [NRD];
  logic [XLEN-1:0] rd_d [NRD];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_commit;

  regfile_clear_seq #(
    .NREGS(NREGS)
  ) u_clear_seq (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .ready_o   (ready)
  );

  assign wr_commit = we && ready && (wa != '0);
  // Writes arriving before the clear finishes are lost; reset itself never reports a drop
  assign wr_drop   = Rst && we && !ready;

  // Storage: the clear sweep owns the array until ready, then normal writes take over
  always_ff @(posedge Clk) begin
    if (Rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (wr_commit) begin
        mem[wa] <= wd;
      end
    end
  end

  // Next read data per port: zero while clearing or for x0, optional forwarding of a same-cycle write
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_d[i] = '0;
      if (ready && (rs_addr[i*AW +: AW] != '0)) begin
        rd_d[i] = mem[rs_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (wa == rs_addr[i*AW +: AW])) begin
          rd_d[i] = wd;
        end
`endif
      end
    end
  end

  // Registered read ports
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NRD; i++) begin
      if (!Rst) begin
        rd_q[i] <= '0;
      end else begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  // Pack the read ports onto the output bus
  always_comb begin
    rs_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rs_data[i*XLEN +: XLEN] = rd_q[i];
    end
  end

endmodule
